// File: rtl/cfg_bank_pkg.sv
// Shared definitions for the PWM/output config bank arbiter: register
// addresses, requester index type and the address decoder.
package cfg_bank_pkg;

    localparam int NUM_CFG_REGS = 5;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;
    localparam logic [6:0] ADDR_COMMIT    = 7'h7F;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_t;

    typedef logic [7:0] cfg_byte_t;

    typedef enum logic [1:0] {
        DEC_REG,
        DEC_COMMIT,
        DEC_BAD
    } dec_kind_t;

    typedef struct packed {
        dec_kind_t  kind;
        logic [2:0] idx;
    } dec_t;

    // Register addresses map one-to-one onto bank slots 0..4; the commit
    // address is only meaningful when the shadow feature is built in.
    function automatic dec_t decode_addr(input logic [6:0] addr, input logic commit_en);
        dec_t d;
        d.kind = DEC_BAD;
        d.idx  = 3'd0;
        case (addr)
            ADDR_EN_OUT_LO, ADDR_EN_OUT_HI, ADDR_EN_PWM_LO,
            ADDR_EN_PWM_HI, ADDR_DUTY: begin
                d.kind = DEC_REG;
                d.idx  = addr[2:0];
            end
            ADDR_COMMIT: begin
                if (commit_en) begin
                    d.kind = DEC_COMMIT;
                end
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cfg_bank_arbiter_if.sv
// One write-requester port: valid/ready handshake carrying a 7-bit register
// address and 8-bit data. The requester drives the master side.
interface cfg_bank_arbiter_if;
    logic       valid;
    logic       ready;
    logic [6:0] addr;
    logic [7:0] data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/cfg_bank_arbiter_rr_arb2.sv
// Two-requester grant logic. Grant is combinational from the valids and the
// registered last_grant; ties go to the requester not served last
// (FIXED_PRI=0) or always to req0 (FIXED_PRI=1). Ready is held low in reset.
module rr_arb2
    import cfg_bank_pkg::*;
#(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     valid0,
    input  logic     valid1,
    output logic     ready0,
    output logic     ready1,
    output logic     transfer,
    output req_idx_t grant_idx,
    output req_idx_t last_grant
);

    req_idx_t last_q;
    logic     grant0;
    logic     grant1;

    // Pick at most one winner from the current valids.
    always_comb begin
        // NOTE: defaults first so every path assigns both grants; no latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        case ({valid1, valid0})
            2'b01: grant0 = 1'b1;
            2'b10: grant1 = 1'b1;
            2'b11: begin
                if (FIXED_PRI || last_q == REQ1) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ready0     = grant0 & rst_n;
    assign ready1     = grant1 & rst_n;
    assign transfer   = ready0 | ready1;
    assign grant_idx  = ready1 ? REQ1 : REQ0;
    assign last_grant = last_q;

    // Remember who was served last; reset favours req0 on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignment so all flops sample together.
        if (!rst_n) begin
            last_q <= REQ1;
        end else if (transfer) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/cfg_bank_arbiter.sv
// Config register bank shared by two write requesters (SPI decoder on req0,
// local agent on req1). Arbitrates, decodes the address, updates the five
// PWM/output registers and counts writes to undecoded addresses.
// Optional feature macro CFG_ARB_SHADOW_EN: writes are staged in shadow
// registers and published together by a write to ADDR_COMMIT.
module cfg_bank_arbiter
    import cfg_bank_pkg::*;
#(
    parameter int BAD_CNT_W = 8,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cfg_bank_arbiter_if.slave    req0,
    cfg_bank_arbiter_if.slave    req1,
    output logic [7:0]           en_reg_out_7_0,
    output logic [7:0]           en_reg_out_15_8,
    output logic [7:0]           en_reg_pwm_7_0,
    output logic [7:0]           en_reg_pwm_15_8,
    output logic [7:0]           pwm_duty_cycle,
    output logic                 last_grant,
    output logic [BAD_CNT_W-1:0] bad_addr_cnt,
    output logic                 shadow_pending
);

`ifdef CFG_ARB_SHADOW_EN
    localparam logic COMMIT_EN = 1'b1;
`else
    localparam logic COMMIT_EN = 1'b0;
`endif

    logic      ready0;
    logic      ready1;
    logic      transfer;
    req_idx_t  grant_idx;
    req_idx_t  last_idx;
    logic [6:0] sel_addr;
    cfg_byte_t sel_data;
    dec_t      dec;

    cfg_byte_t            cfg_q [NUM_CFG_REGS];
    logic [BAD_CNT_W-1:0] bad_cnt_q;

    rr_arb2 #(.FIXED_PRI(FIXED_PRI)) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid0     (req0.valid),
        .valid1     (req1.valid),
        .ready0     (ready0),
        .ready1     (ready1),
        .transfer   (transfer),
        .grant_idx  (grant_idx),
        .last_grant (last_idx)
    );

    assign req0.ready = ready0;
    assign req1.ready = ready1;
    assign last_grant = last_idx;

    assign sel_addr = (grant_idx == REQ1) ? req1.addr : req0.addr;
    assign sel_data = (grant_idx == REQ1) ? req1.data : req0.data;
    assign dec      = decode_addr(sel_addr, COMMIT_EN);

`ifdef CFG_ARB_SHADOW_EN
    cfg_byte_t shadow_q [NUM_CFG_REGS];
    logic      pending_q;

    // Stage decoded writes; a commit publishes every shadow at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CFG_REGS; i++) begin
                shadow_q[i] <= '0;
                cfg_q[i]    <= '0;
            end
            pending_q <= 1'b0;
        end else if (transfer) begin
            case (dec.kind)
                DEC_REG: begin
                    shadow_q[dec.idx] <= sel_data;
                    pending_q         <= 1'b1;
                end
                DEC_COMMIT: begin
                    for (int i = 0; i < NUM_CFG_REGS; i++) begin
                        cfg_q[i] <= shadow_q[i];
                    end
                    pending_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign shadow_pending = pending_q;
`else
    // Decoded writes land directly in the output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the bank is a handful of flops driving outputs, so it is reset.
        if (!rst_n) begin
            for (int i = 0; i < NUM_CFG_REGS; i++) begin
                cfg_q[i] <= '0;
            end
        end else if (transfer && dec.kind == DEC_REG) begin
            cfg_q[dec.idx] <= sel_data;
        end
    end

    assign shadow_pending = 1'b0;
`endif

    // Count completed writes to undecoded addresses, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_cnt_q <= '0;
        end else if (transfer && dec.kind == DEC_BAD && bad_cnt_q != '1) begin
            bad_cnt_q <= bad_cnt_q + BAD_CNT_W'(1);
        end
    end

    assign bad_addr_cnt    = bad_cnt_q;
    assign en_reg_out_7_0  = cfg_q[ADDR_EN_OUT_LO[2:0]];
    assign en_reg_out_15_8 = cfg_q[ADDR_EN_OUT_HI[2:0]];
    assign en_reg_pwm_7_0  = cfg_q[ADDR_EN_PWM_LO[2:0]];
    assign en_reg_pwm_15_8 = cfg_q[ADDR_EN_PWM_HI[2:0]];
    assign pwm_duty_cycle  = cfg_q[ADDR_DUTY[2:0]];

endmodule
